// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter and its per-source FIFOs.
package wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 6;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [PREG_W-1:0] pd;
    logic              regwr;
    logic [ROB_W-1:0]  tag_rob;
  } cdb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO; stall asserts one entry early to absorb the result already in flight.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t dout,
  output logic       empty,
  output logic       stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  cdb_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == FULL_CNT);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign stall     = (count_r >= STALL_CNT);
  assign do_pop_s  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push && !flush && (!full_s || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      overflow_r <= overflow_r | (push && full_s && !do_pop_s);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges per-source FIFOs onto the common data bus with round-robin grant and registered broadcast.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_back,
  input  logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_result,
  input  logic [NUM_SRC-1:0][PREG_W-1:0]  src_pd,
  input  logic [NUM_SRC-1:0]              src_regwr,
  input  logic [NUM_SRC-1:0][ROB_W-1:0]   src_tag_rob,
  output logic [NUM_SRC-1:0]              src_stall,
  output logic                            cdb_valid,
  output logic [DATA_W-1:0]               cdb_result,
  output logic [PREG_W-1:0]               cdb_pd,
  output logic                            cdb_regwr,
  output logic [ROB_W-1:0]                cdb_tag_rob
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_valid_s;
  logic [NUM_SRC-1:0] empty_s;
  logic [NUM_SRC-1:0] pop_s;
  cdb_entry_t         head_s [NUM_SRC];
  cdb_entry_t         grant_entry_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_entry_t din_s;
    assign din_s    = {src_result[i], src_pd[i], src_regwr[i], src_tag_rob[i]};
    assign pop_s[i] = grant_valid_s && (grant_idx_s == IDX_W'(i));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_back),
      .push  (src_ready[i]),
      .pop   (pop_s[i]),
      .din   (din_s),
      .dout  (head_s[i]),
      .empty (empty_s[i]),
      .stall (src_stall[i])
    );
  end

  // Round-robin search: first non-empty source after the last one granted.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand          = 0;
    cand_idx      = {IDX_W{1'b0}};
    grant_valid_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand     = (int'(rr_ptr_r) + k) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!grant_valid_s && !empty_s[cand_idx]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand_idx;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    grant_entry_s = head_s[grant_idx_s];
  end

  // CDB broadcast registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_result  <= {DATA_W{1'b0}};
      cdb_pd      <= {PREG_W{1'b0}};
      cdb_regwr   <= 1'b0;
      cdb_tag_rob <= {ROB_W{1'b0}};
      rr_ptr_r    <= LAST_IDX;
    end else if (flush_back) begin
      cdb_valid   <= 1'b0;
      cdb_result  <= {DATA_W{1'b0}};
      cdb_pd      <= {PREG_W{1'b0}};
      cdb_regwr   <= 1'b0;
      cdb_tag_rob <= {ROB_W{1'b0}};
      rr_ptr_r    <= LAST_IDX;
    end else if (grant_valid_s) begin
      cdb_valid   <= 1'b1;
      cdb_result  <= grant_entry_s.result;
      cdb_pd      <= grant_entry_s.pd;
      cdb_regwr   <= grant_entry_s.regwr;
      cdb_tag_rob <= grant_entry_s.tag_rob;
      rr_ptr_r    <= grant_idx_s;
    end else begin
      cdb_valid   <= 1'b0;
      cdb_result  <= {DATA_W{1'b0}};
      cdb_pd      <= {PREG_W{1'b0}};
      cdb_regwr   <= 1'b0;
      cdb_tag_rob <= {ROB_W{1'b0}};
      rr_ptr_r    <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations and a per-source order scoreboard.
module tb_wb_arbiter;

  logic             clk;
  logic             rst;
  logic             flush_back;
  logic [3:0]       src_ready;
  logic [3:0][31:0] src_result;
  logic [3:0][5:0]  src_pd;
  logic [3:0]       src_regwr;
  logic [3:0][5:0]  src_tag_rob;
  logic [3:0]       src_stall;
  logic             cdb_valid;
  logic [31:0]      cdb_result;
  logic [5:0]       cdb_pd;
  logic             cdb_regwr;
  logic [5:0]       cdb_tag_rob;

  int checks;
  int errors;
  logic [31:0] exp_q [4][$];

  wb_arbiter #(.NUM_SRC(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_back  (flush_back),
    .src_ready   (src_ready),
    .src_result  (src_result),
    .src_pd      (src_pd),
    .src_regwr   (src_regwr),
    .src_tag_rob (src_tag_rob),
    .src_stall   (src_stall),
    .cdb_valid   (cdb_valid),
    .cdb_result  (cdb_result),
    .cdb_pd      (cdb_pd),
    .cdb_regwr   (cdb_regwr),
    .cdb_tag_rob (cdb_tag_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [1:0] s, input logic [31:0] r, input logic [5:0] pd,
                         input logic wr, input logic [5:0] tag);
    src_result[s]  = r;
    src_pd[s]      = pd;
    src_regwr[s]   = wr;
    src_tag_rob[s] = tag;
  endtask

  task automatic sb_check();
    logic [1:0]  s;
    logic [31:0] e;
    if (cdb_valid) begin
      s = cdb_tag_rob[5:4];
      if (exp_q[s].size() == 0) begin
        check("sb_spurious", {32'h0, cdb_result}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q[s].pop_front();
        check("sb_order", {32'h0, cdb_result}, {32'h0, e});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    flush_back  = 1'b0;
    src_ready   = 4'b0000;
    src_result  = '0;
    src_pd      = '0;
    src_regwr   = '0;
    src_tag_rob = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  {63'h0, cdb_valid}, 64'd0);
    check("rst_result", {32'h0, cdb_result}, 64'd0);
    check("rst_stall",  {60'h0, src_stall}, 64'd0);
    check("rst_rr",     {62'h0, dut.rr_ptr_r}, 64'd3);
    rst = 1'b0;

    // Single result on source 2, no bypass, two-cycle latency.
    set_src(2'd2, 32'hDEAD_BEEF, 6'd5, 1'b1, 6'd9);
    src_ready = 4'b0100;
    tick();
    check("single_nobypass", {63'h0, cdb_valid}, 64'd0);
    src_ready = 4'b0000;
    tick();
    check("single_valid",  {63'h0, cdb_valid}, 64'd1);
    check("single_result", {32'h0, cdb_result}, 64'hDEAD_BEEF);
    check("single_pd",     {58'h0, cdb_pd}, 64'd5);
    check("single_tag",    {58'h0, cdb_tag_rob}, 64'd9);
    check("single_regwr",  {63'h0, cdb_regwr}, 64'd1);
    tick();
    check("single_idle_valid",  {63'h0, cdb_valid}, 64'd0);
    check("single_idle_result", {32'h0, cdb_result}, 64'd0);

    // Flush restores rr_ptr=3, then all four contend.
    flush_back = 1'b1;
    tick();
    flush_back = 1'b0;
    check("flush_rr", {62'h0, dut.rr_ptr_r}, 64'd3);
    for (int i = 0; i < 4; i++) begin
      set_src(2'(i), 32'h1000 + 32'(i), 6'(10 + i), i[0], 6'(i));
    end
    src_ready = 4'b1111;
    tick();
    src_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_valid",  {63'h0, cdb_valid}, 64'd1);
      check("cont_result", {32'h0, cdb_result}, 64'h1000 + 64'(i));
      check("cont_src",    {58'h0, cdb_tag_rob}, 64'(i));
      check("cont_regwr",  {63'h0, cdb_regwr}, 64'(i % 2));
    end
    tick();
    check("cont_idle", {63'h0, cdb_valid}, 64'd0);

    // Sources 0 and 1 both push whenever not stalled; source 0 reaches count 3 after edge 5.
    for (int n = 1; n <= 12; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (!src_stall[s]) begin
          r = 32'hA000_0000 | 32'(s << 8) | 32'(n);
          set_src(2'(s), r, 6'(n), 1'b1, 6'((s << 4) | n));
          src_ready[s] = 1'b1;
          exp_q[s].push_back(r);
        end else begin
          src_ready[s] = 1'b0;
        end
      end
      tick();
      sb_check();
      if (n == 4) check("stall0_low", {63'h0, src_stall[0]}, 64'd0);
      if (n == 5) begin
        check("stall0_rise", {63'h0, src_stall[0]}, 64'd1);
        check("stall0_cnt",  {61'h0, dut.g_src[0].u_fifo.count_r}, 64'd3);
      end
    end
    src_ready = 4'b0000;
    repeat (10) begin
      tick();
      sb_check();
    end
    check("sb_drain0", 64'(exp_q[0].size()), 64'd0);
    check("sb_drain1", 64'(exp_q[1].size()), 64'd0);
    check("no_ovf0", {63'h0, dut.g_src[0].u_fifo.overflow_r}, 64'd0);
    check("no_ovf1", {63'h0, dut.g_src[1].u_fifo.overflow_r}, 64'd0);

    // Flush with three entries buffered and a new input on source 3.
    for (int i = 0; i < 3; i++) set_src(2'(i), 32'h5000 + 32'(i), 6'd1, 1'b1, 6'(i));
    src_ready = 4'b0111;
    tick();
    check("flush_pre_valid", {63'h0, cdb_valid}, 64'd0);
    set_src(2'd3, 32'hBAD0_BAD0, 6'd3, 1'b1, 6'd3);
    src_ready  = 4'b1000;
    flush_back = 1'b1;
    tick();
    flush_back = 1'b0;
    src_ready  = 4'b0000;
    check("flush_valid", {63'h0, cdb_valid}, 64'd0);
    check("flush_cnt0", {61'h0, dut.g_src[0].u_fifo.count_r}, 64'd0);
    check("flush_cnt1", {61'h0, dut.g_src[1].u_fifo.count_r}, 64'd0);
    check("flush_cnt2", {61'h0, dut.g_src[2].u_fifo.count_r}, 64'd0);
    check("flush_cnt3", {61'h0, dut.g_src[3].u_fifo.count_r}, 64'd0);
    repeat (3) begin
      tick();
      check("flush_nostale", {63'h0, cdb_valid}, 64'd0);
    end

    // Asynchronous reset between edges with two entries still buffered.
    for (int i = 0; i < 3; i++) set_src(2'(i), 32'h7000 + 32'(i), 6'd2, 1'b1, 6'(i));
    src_ready = 4'b0111;
    tick();
    src_ready = 4'b0000;
    tick();
    check("ar_pre_valid", {63'h0, cdb_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid",  {63'h0, cdb_valid}, 64'd0);
    check("ar_result", {32'h0, cdb_result}, 64'd0);
    check("ar_cnt1",   {61'h0, dut.g_src[1].u_fifo.count_r}, 64'd0);
    check("ar_cnt2",   {61'h0, dut.g_src[2].u_fifo.count_r}, 64'd0);
    check("ar_stall",  {60'h0, src_stall}, 64'd0);
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("ar_nostale", {63'h0, cdb_valid}, 64'd0);
    end

    // Ten back-to-back pushes on source 1: pointers wrap twice.
    for (int n = 0; n < 10; n++) begin
      set_src(2'd1, 32'hC0DE_0000 + 32'(n), 6'(n), 1'b1, 6'(n));
      src_ready = 4'b0010;
      tick();
      if (n > 0) begin
        check("wrap_valid",  {63'h0, cdb_valid}, 64'd1);
        check("wrap_result", {32'h0, cdb_result}, 64'hC0DE_0000 + 64'(n - 1));
      end
    end
    src_ready = 4'b0000;
    tick();
    check("wrap_last",   {32'h0, cdb_result}, 64'hC0DE_0009);
    check("wrap_wr_ptr", {62'h0, dut.g_src[1].u_fifo.wr_ptr_r}, 64'd2);
    check("wrap_rd_ptr", {62'h0, dut.g_src[1].u_fifo.rd_ptr_r}, 64'd2);
    tick();
    check("wrap_idle", {63'h0, cdb_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of functional-unit result sources merged onto the common data bus (CDB).
REQ-002 Parameter DEPTH, default 4, entries per source FIFO, power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush_back  input  1  back-end flush; discards all buffered and in-flight results.
REQ-006 src_ready  input  [NUM_SRC]  per-source result-valid, same meaning as a unit's registered ready.
REQ-007 src_result  input  [NUM_SRC][32]  per-source result data.
REQ-008 src_pd  input  [NUM_SRC][6]  per-source destination physical register.
REQ-009 src_regwr  input  [NUM_SRC]  per-source register-write enable.
REQ-010 src_tag_rob  input  [NUM_SRC][6]  per-source ROB tag.
REQ-011 src_stall  output  [NUM_SRC]  per-source almost-full, used to hold issue to that unit.
REQ-012 cdb_valid, cdb_result, cdb_pd, cdb_regwr, cdb_tag_rob  output  1/32/6/1/6  registered CDB broadcast.

Function
REQ-013 Each source SHALL own one FIFO of DEPTH entries of {result, pd, regwr, tag_rob}, with a count of width clog2(DEPTH)+1.
REQ-014 A FIFO SHALL push on a posedge where src_ready=1 and flush_back=0; src_ready=0 SHALL never push.
REQ-015 src_stall[i] SHALL be combinational and equal 1 when count[i] >= DEPTH-1, covering the one registered result already in flight.
REQ-016 A push into a full FIFO SHALL drop the entry and set a sticky overflow flag visible to simulation assertions only; correct use of stall never produces this case.
REQ-017 Each cycle the arbiter SHALL grant exactly one non-empty FIFO, chosen round-robin starting at index rr_ptr+1 modulo NUM_SRC.
REQ-018 On grant of source g: pop head of g; rr_ptr <= g; CDB registers <= head fields with cdb_valid=1.
REQ-019 With no non-empty FIFO: cdb_valid <= 0, the other CDB fields <= 0, and rr_ptr holds.
REQ-020 Latency SHALL be 2 cycles with no contention: push at edge k, broadcast valid after edge k+1; there is no input-to-CDB bypass.
REQ-021 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and keep entry order, including when the FIFO is full.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; order within a source SHALL be strict FIFO.
REQ-023 Throughput SHALL be one result per cycle total; sustained ready on all sources SHALL give each source 1/NUM_SRC of the slots.
REQ-024 A posedge with flush_back=1 SHALL empty all FIFOs, clear all CDB outputs to 0, reset rr_ptr to NUM_SRC-1, and discard that cycle's inputs.
REQ-025 cdb_regwr=0 entries SHALL still be broadcast so the ROB sees completion.

Reset
REQ-026 While rst=1: all FIFO counts and pointers are 0, rr_ptr=NUM_SRC-1, all cdb_* outputs are 0, and src_stall=0.
REQ-027 Assertion of rst mid-operation SHALL discard all buffered entries immediately, asynchronously, without waiting for clk.

Structure
REQ-028 A shared package SHALL hold the cdb_entry_t typedef {result[32], pd[6], regwr, tag_rob[6]} and the PREG_W=6 and ROB_W=6 constants.
REQ-029 The per-source FIFO SHALL be one sub-module, wb_fifo, instantiated NUM_SRC times; the arbiter and CDB registers stay in wb_arbiter.

Verification
REQ-030 Single result: src_ready[2]=1 at edge 0 with pd=5, tag=9, result=0xDEADBEEF -> after edge 1, cdb_valid=1 with those fields; after edge 2, cdb_valid=0.
REQ-031 Contention: all 4 sources ready at edge 0 with rr_ptr=3 -> broadcasts after edges 1-4 come from sources 0, 1, 2, 3 in order.
REQ-032 Stall: source 0 pushes each cycle while source 1 hogs the grants -> src_stall[0] rises when count=3, no overflow occurs, and order is preserved.
REQ-033 Flush: 3 entries buffered and flush_back=1 together with a new src_ready -> next cycle all counts are 0 and cdb_valid=0, and the new input never appears.
REQ-034 Async reset: rst pulsed between edges with 2 entries buffered -> outputs are 0 before the next edge, and no stale entry is broadcast afterwards.
REQ-035 Wrap: 10 back-to-back pushes on one source with no contention -> 10 broadcasts in order, pointers wrap twice, and the data matches.
